// File: rtl/decode_stage_pipe.sv
// Single-issue decode stage: opcode decode, 8-entry register file, pending-write
// scoreboard for RAW/WAW stalls, and a registered valid/ready bundle toward execute.
module decode_stage_pipe #(
  parameter int DATA_W = 16,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [2:0]        wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rd1,
  output logic [DATA_W-1:0] out_rd2,
  output logic [DATA_W-1:0] out_imm,
  output logic [2:0]        out_alu_op,
  output logic              out_mem_rd,
  output logic              out_mem_wr,
  output logic              out_reg_wr,
  output logic [2:0]        out_wsel,
  output logic              out_br_ju,
  output logic              out_err
);

  typedef struct packed {
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [2:0]        alu_op;
    logic              mem_rd;
    logic              mem_wr;
    logic              reg_wr;
    logic [2:0]        wsel;
    logic              br_ju;
    logic              err;
  } bundle_t;

  logic [4:0] op;
  logic [2:0] rs, rt, rd;
  logic [1:0] func;

  assign op   = instr[15:11];
  assign rs   = instr[10:8];
  assign rt   = instr[7:5];
  assign rd   = instr[4:2];
  assign func = instr[1:0];

  // instruction_ctl: op -> control. Unlisted opcodes decode as a NOP.
  logic [1:0] regdst;
  logic [2:0] alu_op;
  logic       mem_rd, mem_wr, reg_wr, br_ju;

  always_comb begin
    regdst = 2'd0;
    alu_op = 3'd0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    reg_wr = 1'b0;
    br_ju  = 1'b0;
    case (op)
      5'd0: begin regdst = 2'd2; reg_wr = 1'b1; alu_op = {1'b0, func}; end
      5'd1: begin regdst = 2'd1; reg_wr = 1'b1; alu_op = 3'b100; end
      5'd2: begin regdst = 2'd1; reg_wr = 1'b1; mem_rd = 1'b1; alu_op = 3'b100; end
      5'd3: begin regdst = 2'd1; mem_wr = 1'b1; alu_op = 3'b100; end
      5'd4: begin br_ju = 1'b1; alu_op = 3'b001; end
      5'd5: begin br_ju = 1'b1; end
      5'd6: begin reg_wr = 1'b1; alu_op = 3'b101; end
      5'd7: begin regdst = 2'd3; reg_wr = 1'b1; end
      default: ;
    endcase
  end

  logic [2:0]        wsel;
  logic              err;
  logic [DATA_W-1:0] imm;

  always_comb begin
    wsel = rs;
    err  = 1'b0;
    case (regdst)
      2'd1:    wsel = rt;
      2'd2:    wsel = rd;
      2'd3:    begin wsel = rd; err = 1'b1; end
      default: wsel = rs;
    endcase
    if (regdst == 2'd1) imm = {{(DATA_W-5){instr[4]}}, instr[4:0]};
    else                imm = {{(DATA_W-8){instr[7]}}, instr[7:0]};
  end

  logic [DATA_W-1:0] rf_q [8];
  logic [DATA_W-1:0] rf_d [8];
  logic [7:0]        pend_q, pend_d;
  logic              out_valid_q, out_valid_d;
  bundle_t           bundle_q, bundle_d, dec_bundle;

  // A writeback landing this cycle satisfies a read only when forwarding is enabled.
  logic byp_rs, byp_rt, hz, adv, accept;

  assign byp_rs = BYPASS && wb_en && (wb_sel == rs);
  assign byp_rt = BYPASS && wb_en && (wb_sel == rt);
  assign hz     = (pend_q[rs] && !byp_rs) || (pend_q[rt] && !byp_rt) || (reg_wr && pend_q[wsel]);
  assign adv    = !out_valid_q || out_ready;
  assign in_ready = rst && adv && !hz && !flush;
  assign accept = in_valid && in_ready;

  always_comb begin
    dec_bundle.rd1    = byp_rs ? wb_data : rf_q[rs];
    dec_bundle.rd2    = byp_rt ? wb_data : rf_q[rt];
    dec_bundle.imm    = imm;
    dec_bundle.alu_op = alu_op;
    dec_bundle.mem_rd = mem_rd;
    dec_bundle.mem_wr = mem_wr;
    dec_bundle.reg_wr = reg_wr;
    dec_bundle.wsel   = wsel;
    dec_bundle.br_ju  = br_ju;
    dec_bundle.err    = err;
  end

  // Scoreboard: wb clear, then accept set (set wins), then flush kill overrides both.
  always_comb begin
    rf_d   = rf_q;
    pend_d = pend_q;
    if (wb_en) begin
      rf_d[wb_sel]   = wb_data;
      pend_d[wb_sel] = 1'b0;
    end
    if (accept && reg_wr) pend_d[wsel] = 1'b1;
    if (flush && out_valid_q && bundle_q.reg_wr) pend_d[bundle_q.wsel] = 1'b0;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      bundle_d    = dec_bundle;
    end else if (adv) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_q        <= '{default: '0};
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else begin
      rf_q        <= rf_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_rd1    = bundle_q.rd1;
  assign out_rd2    = bundle_q.rd2;
  assign out_imm    = bundle_q.imm;
  assign out_alu_op = bundle_q.alu_op;
  assign out_mem_rd = bundle_q.mem_rd;
  assign out_mem_wr = bundle_q.mem_wr;
  assign out_reg_wr = bundle_q.reg_wr;
  assign out_wsel   = bundle_q.wsel;
  assign out_br_ju  = bundle_q.br_ju;
  assign out_err    = bundle_q.err;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: one forwarding and one non-forwarding instance share
// stimulus; a cycle-level reference model tracks each through directed and random steps.
module tb_decode_stage_pipe;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, flush = 1'b0, wb_en = 1'b0, out_ready = 1'b0;
  logic [15:0]   instr = '0;
  logic [2:0]    wb_sel = '0;
  logic [DW-1:0] wb_data = '0;

  logic [1:0]         in_ready, out_valid, out_mem_rd, out_mem_wr, out_reg_wr, out_br_ju, out_err;
  logic [1:0][DW-1:0] out_rd1, out_rd2, out_imm;
  logic [1:0][2:0]    out_alu_op, out_wsel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance 0 forwards writeback data, instance 1 does not.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    decode_stage_pipe #(.DATA_W(DW), .BYPASS(g == 0 ? 1'b1 : 1'b0)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[g]), .instr(instr),
      .flush(flush), .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
      .out_valid(out_valid[g]), .out_ready(out_ready), .out_rd1(out_rd1[g]), .out_rd2(out_rd2[g]),
      .out_imm(out_imm[g]), .out_alu_op(out_alu_op[g]), .out_mem_rd(out_mem_rd[g]),
      .out_mem_wr(out_mem_wr[g]), .out_reg_wr(out_reg_wr[g]), .out_wsel(out_wsel[g]),
      .out_br_ju(out_br_ju[g]), .out_err(out_err[g])
    );
  end

  typedef struct {
    int regdst;
    int alu;
    bit reg_wr, mem_rd, mem_wr, br_ju;
  } dec_t;

  logic [DW-1:0] m_rf   [2][8];
  bit            m_pend [2][8];
  logic [63:0]   m_bun  [2];

  function automatic dec_t ref_decode(logic [15:0] ins);
    dec_t d;
    int   op;
    d  = '{regdst: 0, alu: 0, reg_wr: 0, mem_rd: 0, mem_wr: 0, br_ju: 0};
    op = int'(ins[15:11]);
    case (op)
      0: begin d.regdst = 2; d.reg_wr = 1; d.alu = int'(ins[1:0]); end
      1: begin d.regdst = 1; d.reg_wr = 1; d.alu = 4; end
      2: begin d.regdst = 1; d.reg_wr = 1; d.mem_rd = 1; d.alu = 4; end
      3: begin d.regdst = 1; d.mem_wr = 1; d.alu = 4; end
      4: begin d.br_ju = 1; d.alu = 1; end
      5: begin d.br_ju = 1; end
      6: begin d.reg_wr = 1; d.alu = 5; end
      7: begin d.regdst = 3; d.reg_wr = 1; end
      default: ;
    endcase
    return d;
  endfunction

  // Bit layout: [59]=valid [58:43]=rd1 [42:27]=rd2 [26:11]=imm [10:8]=alu
  // [7]=mem_rd [6]=mem_wr [5]=reg_wr [4:2]=wsel [1]=br_ju [0]=err
  function automatic logic [63:0] pack(bit v, logic [15:0] r1, logic [15:0] r2, logic [15:0] im,
                                       logic [2:0] alu, bit mr, bit mw, bit rw, logic [2:0] ws,
                                       bit bj, bit er);
    return {4'b0, v, r1, r2, im, alu, mr, mw, rw, ws, bj, er};
  endfunction

  function automatic logic [63:0] dut_bundle(int g);
    return pack(out_valid[g], out_rd1[g], out_rd2[g], out_imm[g], out_alu_op[g], out_mem_rd[g],
                out_mem_wr[g], out_reg_wr[g], out_wsel[g], out_br_ju[g], out_err[g]);
  endfunction

  function automatic logic [15:0] mk(int op, int rs, int rt, int rd, int fn);
    return 16'((op << 11) | (rs << 8) | (rt << 5) | (rd << 2) | fn);
  endfunction

  function automatic logic [15:0] mki(int op, int rs, int rt, int imm5);
    return 16'((op << 11) | (rs << 8) | (rt << 5) | (imm5 & 31));
  endfunction

  task automatic checkOutput(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(bit iv, logic [15:0] ins, bit ordy, bit fl,
                               bit we, logic [2:0] ws, logic [15:0] wd);
    in_valid  = iv;
    instr     = ins;
    out_ready = ordy;
    flush     = fl;
    wb_en     = we;
    wb_sel    = ws;
    wb_data   = wd;
  endtask

  task automatic model_inputs(int g, output bit rdy, output bit acc, output logic [63:0] nxt);
    dec_t d = ref_decode(instr);
    int rs = int'(instr[10:8]);
    int rt = int'(instr[7:5]);
    int rd = int'(instr[4:2]);
    bit fwd = (g == 0);
    bit fwd_rs, fwd_rt, hz;
    int ws, imm;
    logic [15:0] v1, v2;
    ws = (d.regdst == 0) ? rs : (d.regdst == 1) ? rt : rd;
    fwd_rs = fwd && wb_en && (int'(wb_sel) == rs);
    fwd_rt = fwd && wb_en && (int'(wb_sel) == rt);
    hz = (m_pend[g][rs] && !fwd_rs) || (m_pend[g][rt] && !fwd_rt) || (d.reg_wr && m_pend[g][ws]);
    rdy = rst && (!m_bun[g][59] || out_ready) && !hz && !flush;
    acc = in_valid && rdy;
    if (d.regdst == 1) begin imm = int'(instr[4:0]); if (imm >= 16) imm -= 32; end
    else begin imm = int'(instr[7:0]); if (imm >= 128) imm -= 256; end
    v1 = fwd_rs ? wb_data : m_rf[g][rs];
    v2 = fwd_rt ? wb_data : m_rf[g][rt];
    nxt = pack(1'b1, v1, v2, 16'(imm), 3'(d.alu), d.mem_rd, d.mem_wr, d.reg_wr, 3'(ws),
               d.br_ju, d.regdst == 3);
  endtask

  task automatic model_clock(int g, bit acc, logic [63:0] nxt);
    bit ov = m_bun[g][59];
    if (wb_en) begin
      m_pend[g][wb_sel] = 1'b0;
      m_rf[g][wb_sel]   = wb_data;
    end
    if (acc && nxt[5]) m_pend[g][nxt[4:2]] = 1'b1;
    if (flush && ov && m_bun[g][5]) m_pend[g][m_bun[g][4:2]] = 1'b0;
    if (flush)                   m_bun[g][59] = 1'b0;
    else if (acc)                m_bun[g] = nxt;
    else if (!ov || out_ready)   m_bun[g][59] = 1'b0;
  endtask

  // Called at a falling edge with inputs already applied.
  task automatic step();
    bit          rdy [2];
    bit          acc [2];
    logic [63:0] nxt [2];
    #1;
    for (int g = 0; g < 2; g++) begin
      model_inputs(g, rdy[g], acc[g], nxt[g]);
      checkOutput($sformatf("in_ready%0d", g), 64'(in_ready[g]), 64'(rdy[g]));
    end
    @(posedge clk);
    for (int g = 0; g < 2; g++) if (rst) model_clock(g, acc[g], nxt[g]);
    @(negedge clk);
    for (int g = 0; g < 2; g++) checkOutput($sformatf("bundle%0d", g), dut_bundle(g), m_bun[g]);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int g = 0; g < 2; g++) begin
      m_bun[g] = '0;
      for (int r = 0; r < 8; r++) begin
        m_rf[g][r]   = '0;
        m_pend[g][r] = 1'b0;
      end
    end
    #1;
    for (int g = 0; g < 2; g++) begin
      checkOutput($sformatf("reset_in_ready%0d", g), 64'(in_ready[g]), 64'd0);
      checkOutput($sformatf("reset_bundle%0d", g), dut_bundle(g), 64'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    do_reset();

    // ADDI r1, imm -3 in the 5-bit field
    applyStimulus(1, mki(1, 0, 1, -3), 1, 0, 0, 0, 0);
    step();
    checkOutput("t1_valid", 64'(out_valid[0]), 64'd1);
    checkOutput("t1_imm", 64'(out_imm[0]), 64'hFFFD);
    checkOutput("t1_wsel", 64'(out_wsel[0]), 64'd1);
    checkOutput("t1_alu", 64'(out_alu_op[0]), 64'd4);
    applyStimulus(1, mk(0, 1, 0, 3, 0), 1, 0, 0, 0, 0);
    #1 checkOutput("t1_pend1_stall", 64'(in_ready[0]), 64'd0);
    step();
    applyStimulus(0, 0, 1, 0, 1, 1, 16'h0007);
    step();

    // RAW on a load result, resolved by writeback
    applyStimulus(1, mki(2, 0, 2, 4), 1, 0, 0, 0, 0);
    step();
    applyStimulus(1, mk(0, 2, 0, 3, 0), 1, 0, 0, 0, 0);
    #1 checkOutput("t2_stall", 64'(in_ready[0]), 64'd0);
    step();
    checkOutput("t2_hold", 64'(in_ready[0]), 64'd0);
    applyStimulus(1, mk(0, 2, 0, 3, 0), 1, 0, 1, 2, 16'h1234);
    #1 checkOutput("t2_byp_ready", 64'(in_ready[0]), 64'd1);
    checkOutput("t2_nobyp_stall", 64'(in_ready[1]), 64'd0);
    step();
    checkOutput("t2_byp_rd1", 64'(out_rd1[0]), 64'h1234);
    checkOutput("t2_nobyp_invalid", 64'(out_valid[1]), 64'd0);
    applyStimulus(1, mk(0, 2, 0, 3, 0), 1, 0, 0, 0, 0);
    #1 checkOutput("t2_nobyp_ready", 64'(in_ready[1]), 64'd1);
    step();
    checkOutput("t2_nobyp_rd1", 64'(out_rd1[1]), 64'h1234);
    applyStimulus(0, 0, 1, 0, 1, 3, 16'h0033);
    step();

    // Downstream backpressure
    applyStimulus(1, mki(1, 0, 6, 5), 1, 0, 0, 0, 0);
    step();
    applyStimulus(1, mki(1, 0, 7, 9), 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("t3_backpressure", 64'(in_ready[0]), 64'd0);
      step();
      checkOutput("t3_stable_imm", 64'(out_imm[0]), 64'd5);
      checkOutput("t3_stable_valid", 64'(out_valid[0]), 64'd1);
    end
    applyStimulus(1, mki(1, 0, 7, 9), 1, 0, 0, 0, 0);
    step();
    checkOutput("t3_next_imm", 64'(out_imm[0]), 64'd9);
    applyStimulus(0, 0, 1, 0, 1, 6, 16'h0600);
    step();
    applyStimulus(0, 0, 1, 0, 1, 7, 16'h0700);
    step();

    // Flush kills a pending write to r5
    applyStimulus(1, mk(0, 0, 0, 5, 1), 1, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    step();
    checkOutput("t4_flushed", 64'(out_valid[0]), 64'd0);
    applyStimulus(1, mk(0, 5, 5, 1, 0), 1, 0, 0, 0, 0);
    #1 checkOutput("t4_no_stall", 64'(in_ready[0]), 64'd1);
    step();
    applyStimulus(0, 0, 1, 0, 1, 1, 16'h0011);
    step();

    // Accept-set beats same-cycle writeback clear; illegal regdst
    applyStimulus(1, mki(1, 0, 3, 2), 1, 0, 1, 3, 16'h00AA);
    step();
    applyStimulus(1, mk(0, 3, 0, 1, 0), 1, 0, 0, 0, 0);
    #1 checkOutput("t5_set_wins", 64'(in_ready[0]), 64'd0);
    step();
    applyStimulus(0, 0, 1, 0, 1, 3, 16'h00AA);
    step();
    applyStimulus(1, mk(7, 0, 0, 2, 0), 1, 0, 1, 4, 16'hBEEF);
    step();
    checkOutput("t5_err", 64'(out_err[0]), 64'd1);
    checkOutput("t5_err_wsel", 64'(out_wsel[0]), 64'd2);
    applyStimulus(1, mki(1, 0, 4, 1), 1, 0, 0, 0, 0);
    step();
    checkOutput("t5_err_once", 64'(out_err[0]), 64'd0);

    // Async reset in the middle of a stall on r4
    applyStimulus(1, mk(0, 4, 0, 1, 0), 1, 0, 0, 0, 0);
    #1 checkOutput("t6_stall", 64'(in_ready[0]), 64'd0);
    step();
    @(posedge clk);
    #2;
    do_reset();
    #1 checkOutput("t6_no_stall", 64'(in_ready[0]), 64'd1);
    step();
    checkOutput("t6_rf_cleared", 64'(out_rd1[0]), 64'd0);
    checkOutput("t6_valid", 64'(out_valid[0]), 64'd1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op > 7) op = op + 10;
      applyStimulus(($urandom % 4) != 0, 16'((op << 11) | ($urandom % 2048)),
                    ($urandom % 4) != 0, ($urandom % 16) == 0,
                    ($urandom % 2) != 0, 3'($urandom % 8), 16'($urandom));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
